// File: rtl/ula_8bit.sv
// ula_8bit: registered 8-bit arithmetic/logic unit.
//
// The adder is built from two 4-bit slices with a ripple carry from the low
// slice into the high slice. All outputs are registered, so there is one
// cycle of latency and one new operation is accepted on every clock.
//
// Optional feature macro: ULA_OVERFLOW_EN
//   defined   - the signed overflow flag is computed and registered.
//   undefined - no overflow logic is built; the overflow port is tied to 0.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous, active-high reset (clears all outputs)
//   a, b      in   8-bit operands
//   s         in   4-bit function select
//   m         in   mode: 0 = arithmetic, 1 = logic
//   c_in      in   carry in (arithmetic mode only)
//   f         out  8-bit result
//   a_eq_b    out  1 when a == b
//   c_out     out  carry out / no-borrow (0 in logic mode)
//   overflow  out  two's-complement overflow (0 in logic mode)

module ula_8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [7:0] f,
    output logic       a_eq_b,
    output logic       c_out,
    output logic       overflow
);

    logic       is_sub;
    logic [7:0] x_op;
    logic [7:0] y_op;
    logic [7:0] x_eff;
    logic [7:0] y_eff;
    logic       slice_cin;
    logic [4:0] lo_sum;
    logic [4:0] hi_sum;
    logic [8:0] sum9;
    logic [9:0] sub_r;
    logic [7:0] arith_f;
    logic       arith_c;
    logic [7:0] logic_f;

    assign is_sub = (s == 4'b1000);

    // X/Y operand selection for the add-based functions
    always_comb begin
        x_op = a;
        y_op = 8'h00;
        unique case (s)
            4'b0000: begin x_op = a;        y_op = 8'h00;   end
            4'b0001: begin x_op = a | b;    y_op = 8'h00;   end
            4'b0010: begin x_op = a | ~b;   y_op = 8'h00;   end
            4'b0011: begin x_op = 8'hFF;    y_op = 8'h00;   end
            4'b0100: begin x_op = a;        y_op = a & ~b;  end
            4'b0101: begin x_op = a;        y_op = b;       end
            4'b0110: begin x_op = a;        y_op = ~b;      end
            4'b0111: begin x_op = a & ~b;   y_op = 8'hFF;   end
            4'b1000: begin x_op = a;        y_op = ~b;      end
            4'b1001: begin x_op = a;        y_op = a & b;   end
            4'b1010: begin x_op = b;        y_op = 8'h00;   end
            4'b1011: begin x_op = a & b;    y_op = 8'hFF;   end
            4'b1100: begin x_op = a;        y_op = a;       end
            4'b1101: begin x_op = a | b;    y_op = a;       end
            4'b1110: begin x_op = a | ~b;   y_op = a;       end
            4'b1111: begin x_op = a;        y_op = 8'hFF;   end
            default: begin x_op = a;        y_op = 8'h00;   end
        endcase
    end

    // Subtract runs A + ~B + 1 through the slices; c_in is added afterwards
    // because a carry-in of 2 does not fit the single-bit slice carry.
    assign x_eff     = x_op;
    assign y_eff     = y_op;
    assign slice_cin = is_sub ? 1'b1 : c_in;

    assign lo_sum = {1'b0, x_eff[3:0]} + {1'b0, y_eff[3:0]} + {4'b0000, slice_cin};
    assign hi_sum = {1'b0, x_eff[7:4]} + {1'b0, y_eff[7:4]} + {4'b0000, lo_sum[4]};
    assign sum9   = {hi_sum, lo_sum[3:0]};

    // Can reach 0x200 (A=FF, B=00, c_in=1), hence two carry bits.
    assign sub_r = {1'b0, sum9} + {9'b0, c_in};

    assign arith_f = is_sub ? sub_r[7:0] : sum9[7:0];
    assign arith_c = is_sub ? (sub_r[9:8] != 2'b00) : sum9[8];

    always_comb begin
        logic_f = 8'h00;
        unique case (s)
            4'b0000: logic_f = ~a;
            4'b0001: logic_f = ~(a | b);
            4'b0010: logic_f = ~a & b;
            4'b0011: logic_f = 8'h00;
            4'b0100: logic_f = ~(a & b);
            4'b0101: logic_f = ~b;
            4'b0110: logic_f = a ^ b;
            4'b0111: logic_f = a & ~b;
            4'b1000: logic_f = ~a | b;
            4'b1001: logic_f = ~(a ^ b);
            4'b1010: logic_f = b;
            4'b1011: logic_f = a & b;
            4'b1100: logic_f = 8'hFF;
            4'b1101: logic_f = a | ~b;
            4'b1110: logic_f = a | b;
            4'b1111: logic_f = a;
            default: logic_f = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f      <= 8'h00;
            c_out  <= 1'b0;
            a_eq_b <= 1'b0;
        end else begin
            f      <= m ? logic_f : arith_f;
            c_out  <= m ? 1'b0 : arith_c;
            a_eq_b <= (a == b);
        end
    end

`ifdef ULA_OVERFLOW_EN
    logic [9:0] sub_diff;
    logic       sub_ovf;
    logic       add_ovf;
    logic       arith_ovf;

    // Sign-extended A - B + c_in; the result fits in [-128,127] exactly
    // when the top three bits agree.
    assign sub_diff  = {{2{a[7]}}, a} - {{2{b[7]}}, b} + {9'b0, c_in};
    assign sub_ovf   = (sub_diff[9:7] != 3'b000) && (sub_diff[9:7] != 3'b111);
    assign add_ovf   = (x_op[7] == y_op[7]) && (sum9[7] != x_op[7]);
    assign arith_ovf = is_sub ? sub_ovf : add_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else begin
            overflow <= m ? 1'b0 : arith_ovf;
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ula_8bit.sv
module tb_ula_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] s;
    logic       m;
    logic       c_in;
    logic [7:0] f;
    logic       a_eq_b;
    logic       c_out;
    logic       overflow;

    typedef struct {
        int         id;
        logic [7:0] f;
        logic       c;
        logic       v;
        logic       eq;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   op_id    = 0;

    ula_8bit dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .s        (s),
        .m        (m),
        .c_in     (c_in),
        .f        (f),
        .a_eq_b   (a_eq_b),
        .c_out    (c_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic r, input logic [7:0] ia, input logic [7:0] ib,
                                   input logic [3:0] is, input logic im, input logic ic);
        exp_t       e;
        logic [7:0] x;
        logic [7:0] y;
        logic [8:0] sum;
        int         sd;
        e.id = 0;
        e.f  = 8'h00;
        e.c  = 1'b0;
        e.v  = 1'b0;
        e.eq = 1'b0;
        if (r) return e;
        e.eq = (ia == ib);
        if (im) begin
            case (is)
                4'd0:  e.f = ~ia;
                4'd1:  e.f = ~(ia | ib);
                4'd2:  e.f = ~ia & ib;
                4'd3:  e.f = 8'h00;
                4'd4:  e.f = ~(ia & ib);
                4'd5:  e.f = ~ib;
                4'd6:  e.f = ia ^ ib;
                4'd7:  e.f = ia & ~ib;
                4'd8:  e.f = ~ia | ib;
                4'd9:  e.f = ~(ia ^ ib);
                4'd10: e.f = ib;
                4'd11: e.f = ia & ib;
                4'd12: e.f = 8'hFF;
                4'd13: e.f = ia | ~ib;
                4'd14: e.f = ia | ib;
                default: e.f = ia;
            endcase
        end else if (is == 4'd8) begin
            e.f = 8'(int'(ia) - int'(ib) + int'(ic));
            e.c = (int'(ia) + int'(ic)) >= int'(ib);
            sd  = int'($signed(ia)) - int'($signed(ib)) + int'(ic);
            e.v = (sd > 127) || (sd < -128);
        end else begin
            case (is)
                4'd0:  begin x = ia;       y = 8'h00;     end
                4'd1:  begin x = ia | ib;  y = 8'h00;     end
                4'd2:  begin x = ia | ~ib; y = 8'h00;     end
                4'd3:  begin x = 8'hFF;    y = 8'h00;     end
                4'd4:  begin x = ia;       y = ia & ~ib;  end
                4'd5:  begin x = ia;       y = ib;        end
                4'd6:  begin x = ia;       y = ~ib;       end
                4'd7:  begin x = ia & ~ib; y = 8'hFF;     end
                4'd9:  begin x = ia;       y = ia & ib;   end
                4'd10: begin x = ib;       y = 8'h00;     end
                4'd11: begin x = ia & ib;  y = 8'hFF;     end
                4'd12: begin x = ia;       y = ia;        end
                4'd13: begin x = ia | ib;  y = ia;        end
                4'd14: begin x = ia | ~ib; y = ia;        end
                default: begin x = ia;     y = 8'hFF;     end
            endcase
            sum = 9'(int'(x) + int'(y) + int'(ic));
            e.f = sum[7:0];
            e.c = sum[8];
            e.v = (x[7] == y[7]) && (e.f[7] != x[7]);
        end
`ifndef ULA_OVERFLOW_EN
        e.v = 1'b0;
`endif
        return e;
    endfunction

    task automatic apply(input logic r, input logic [7:0] ia, input logic [7:0] ib,
                         input logic [3:0] is, input logic im, input logic ic);
        exp_t e;
        @(negedge clk);
        rst  = r;
        a    = ia;
        b    = ib;
        s    = is;
        m    = im;
        c_in = ic;
        e    = model(r, ia, ib, is, im, ic);
        e.id = op_id;
        op_id++;
        sb.push_back(e);
    endtask

    // Monitor: each edge's outputs belong to the oldest pending operation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("op%0d f", e.id), f, e.f);
                check($sformatf("op%0d c_out", e.id), {7'b0, c_out}, {7'b0, e.c});
                check($sformatf("op%0d overflow", e.id), {7'b0, overflow}, {7'b0, e.v});
                check($sformatf("op%0d a_eq_b", e.id), {7'b0, a_eq_b}, {7'b0, e.eq});
            end
        end
    end

    initial begin
        int wait_cycles;
        rst  = 1'b1;
        a    = 8'h00;
        b    = 8'h00;
        s    = 4'h0;
        m    = 1'b0;
        c_in = 1'b0;

        // reset state, with a live operation on the inputs
        apply(1'b1, 8'h12, 8'h12, 4'b0101, 1'b0, 1'b1);

        // add
        apply(1'b0, 8'h01, 8'h02, 4'b0101, 1'b0, 1'b0);
        apply(1'b0, 8'h0F, 8'h01, 4'b0101, 1'b0, 1'b0);
        apply(1'b0, 8'h7F, 8'h01, 4'b0101, 1'b0, 1'b0);
        apply(1'b0, 8'hFF, 8'h01, 4'b0101, 1'b0, 1'b0);

        // subtract
        apply(1'b0, 8'h0A, 8'h05, 4'b1000, 1'b0, 1'b0);
        apply(1'b0, 8'h05, 8'h0A, 4'b1000, 1'b0, 1'b0);
        apply(1'b0, 8'h80, 8'h01, 4'b1000, 1'b0, 1'b0);
        apply(1'b0, 8'h05, 8'h05, 4'b1000, 1'b0, 1'b1);
        apply(1'b0, 8'hFF, 8'h00, 4'b1000, 1'b0, 1'b1);
        apply(1'b0, 8'h7F, 8'hFF, 4'b1000, 1'b0, 1'b1);

        // compare
        apply(1'b0, 8'h55, 8'h55, 4'b0011, 1'b1, 1'b0);
        apply(1'b0, 8'h55, 8'h54, 4'b1100, 1'b0, 1'b0);
        apply(1'b0, 8'h55, 8'hD5, 4'b0110, 1'b1, 1'b1);

        // logic, with and without c_in
        apply(1'b0, 8'hF0, 8'h3C, 4'b0110, 1'b1, 1'b0);
        apply(1'b0, 8'hF0, 8'h3C, 4'b1011, 1'b1, 1'b0);
        apply(1'b0, 8'hF0, 8'h3C, 4'b0000, 1'b1, 1'b0);
        apply(1'b0, 8'hF0, 8'h3C, 4'b0110, 1'b1, 1'b1);
        apply(1'b0, 8'hF0, 8'h3C, 4'b1011, 1'b1, 1'b1);
        apply(1'b0, 8'hF0, 8'h3C, 4'b0000, 1'b1, 1'b1);

        // reset during an FF+01 add, then release
        apply(1'b0, 8'h7F, 8'h01, 4'b0101, 1'b0, 1'b0);
        apply(1'b1, 8'hFF, 8'h01, 4'b0101, 1'b0, 1'b0);
        apply(1'b0, 8'h01, 8'h02, 4'b0101, 1'b0, 1'b0);

        // every select in both modes, then random traffic
        for (int i = 0; i < 32; i++)
            apply(1'b0, 8'hA7, 8'h5C, 4'(i % 16), 1'(i / 16), 1'(i % 3 == 0));
        for (int i = 0; i < 400; i++)
            apply(($urandom_range(0, 15) == 0), 8'($urandom), 8'($urandom),
                  4'($urandom), 1'($urandom), 1'($urandom));

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            #2;
            wait_cycles++;
        end
        if (sb.size() != 0)
            check("drain", 8'(sb.size()), 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
